// File: rtl/uart_tx_sched_if.sv
// Request/transmit bundle between the byte requesters, the scheduler and the UART serializer.
// Handshake: req[i] is a level "valid" held until grant[i] pulses for one cycle; that pulse is the "ready"/accept.
interface uart_tx_sched_if;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  uart_data;
    logic        uart_start;
    logic [1:0]  state_dbg;

    modport master (
        output req, req_data, req_last,
        input  grant, owner, busy, uart_data, uart_start, state_dbg
    );

    modport slave (
        input  req, req_data, req_last,
        output grant, owner, busy, uart_data, uart_start, state_dbg
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one busy-less UART serializer among 4 byte requesters.
// Optional packet lock is enabled by defining UART_SCHED_LOCK_EN.
module uart_tx_sched #(
    parameter int CLKS_PER_BIT = 13021,
    parameter int GAP_BITS     = 1
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_sched_if.slave  bus
);
    localparam int          FRAME_CLKS = CLKS_PER_BIT * (10 + GAP_BITS);
    localparam logic [31:0] WAIT_LAST  = 32'(FRAME_CLKS - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] cnt;
    logic [1:0]  owner_q;
    logic [7:0]  data_q;
    logic        any_req;
    logic        wait_last;
    logic        arb_pt;
    logic        arb_go;
    logic [1:0]  rr_win;
    logic [1:0]  win;
    logic        found;
    logic [1:0]  idx;

    assign any_req   = |bus.req;
    assign wait_last = (state == WAIT) && (cnt == WAIT_LAST);
    assign arb_pt    = (state == IDLE) || wait_last;
    assign arb_go    = arb_pt && any_req;

    // Search starts one past the last owner; k=4 wraps back to the owner itself.
    always_comb begin
        rr_win = owner_q;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = owner_q + 2'(k);
            if (!found && bus.req[idx]) begin
                rr_win = idx;
                found  = 1'b1;
            end
        end
    end

`ifdef UART_SCHED_LOCK_EN
    logic lock;

    always_comb begin
        win = rr_win;
        if (lock && bus.req[owner_q]) win = owner_q;
    end

    // A dropped owner request at arbitration releases the lock as well.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock <= 1'b0;
        end else if (arb_go) begin
            lock <= ~bus.req_last[win];
        end else if (arb_pt) begin
            lock <= 1'b0;
        end
    end
`else
    logic unused_last;
    assign unused_last = ^bus.req_last;
    assign win = rr_win;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = SEND;
            SEND:    state_nxt = WAIT;
            WAIT:    if (wait_last) state_nxt = any_req ? SEND : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Winner byte and owner are captured on the edge into SEND and then held for the whole frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= 2'd3;
            data_q  <= 8'h00;
            cnt     <= '0;
        end else begin
            if (arb_go) begin
                owner_q <= win;
                data_q  <= bus.req_data[{win, 3'b000} +: 8];
            end
            if (state == SEND)      cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 32'd1;
        end
    end

    always_comb begin
        bus.grant      = 4'b0000;
        bus.uart_start = 1'b0;
        bus.busy       = (state != IDLE);
        if (state == SEND) begin
            bus.grant      = 4'b0001 << owner_q;
            bus.uart_start = 1'b1;
        end
    end

    assign bus.owner     = owner_q;
    assign bus.uart_data = data_q;
    assign bus.state_dbg = state;
endmodule
